// File: rtl/msrv_muldiv_pkg.sv
// msrv_muldiv_pkg: RV32M funct3 codes, FSM state encoding and decode helpers
// shared by the muldiv unit and the instruction decoder.
package msrv_muldiv_pkg;
    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_e;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    // rs2 is signed only for the fully signed ops
    function automatic logic is_signed(input logic [2:0] f3);
        return f3 == FUNCT3_MULH || f3 == FUNCT3_DIV || f3 == FUNCT3_REM;
    endfunction

    function automatic logic is_signed_rs1(input logic [2:0] f3);
        return is_signed(f3) || f3 == FUNCT3_MULHSU;
    endfunction
endpackage

// File: rtl/msrv_muldiv_signfix.sv
// msrv_muldiv_signfix: conditional two's-complement negate, used both to take
// operand magnitudes and to restore the sign of the result.
module msrv_muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] res_o
);
    assign res_o = neg_i ? -val_i : val_i;
endmodule

// File: rtl/msrv_muldiv_unit.sv
// msrv_muldiv_unit: iterative RV32M multiply/divide, one result bit per cycle,
// with single-cycle fast paths for divide-by-zero and signed overflow.
module msrv_muldiv_unit
    import msrv_muldiv_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             ms_riscv32_mp_clk_in,
    input  logic             ms_riscv32_mp_rst_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [2:0]       funct3_in,
    input  logic [WIDTH-1:0] op_1_in,
    input  logic [WIDTH-1:0] op_2_in,
    input  logic             flush_in,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] result_out,
    output logic             busy_out
);
    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [2:0]             f3_q;
    logic [2*WIDTH-1:0]     acc_q, acc_d, raw, fixed;
    logic [WIDTH-1:0]       b_q, result_q, mag1, mag2, fast_res, rem_n, res_d;
    logic [WIDTH:0]         sum, shl, diff;
    logic                   neg_q, s1, s2, div_zero, ovf, ge;

    assign s1 = is_signed_rs1(funct3_in) & op_1_in[WIDTH-1];
    assign s2 = is_signed(funct3_in) & op_2_in[WIDTH-1];

    msrv_muldiv_signfix #(.WIDTH(WIDTH)) u_mag1 (.val_i(op_1_in), .neg_i(s1), .res_o(mag1));
    msrv_muldiv_signfix #(.WIDTH(WIDTH)) u_mag2 (.val_i(op_2_in), .neg_i(s2), .res_o(mag2));

    assign div_zero = is_div(funct3_in) && op_2_in == '0;
    assign ovf      = is_div(funct3_in) && is_signed(funct3_in) && &op_2_in
                   && op_1_in == {1'b1, {(WIDTH-1){1'b0}}};
    assign fast_res = div_zero ? (funct3_in[1] ? op_1_in : '1) : (funct3_in[1] ? '0 : op_1_in);

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    assign sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign shl   = acc_q[2*WIDTH-1:WIDTH-1];
    assign diff  = shl - {1'b0, b_q};
    assign ge    = shl >= {1'b0, b_q};
    assign rem_n = ge ? diff[WIDTH-1:0] : shl[WIDTH-1:0];
    assign acc_d = is_div(f3_q) ? {rem_n, acc_q[WIDTH-2:0], ge} : {sum, acc_q[WIDTH-1:1]};
    assign raw   = !is_div(f3_q) ? acc_d
                 : f3_q[1] ? {{WIDTH{1'b0}}, acc_d[2*WIDTH-1:WIDTH]} : {{WIDTH{1'b0}}, acc_d[WIDTH-1:0]};

    msrv_muldiv_signfix #(.WIDTH(2*WIDTH)) u_fix (.val_i(raw), .neg_i(neg_q), .res_o(fixed));

    assign res_d = (f3_q == FUNCT3_MUL || is_div(f3_q)) ? fixed[WIDTH-1:0] : fixed[2*WIDTH-1:WIDTH];

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            valid_out <= 1'b0;
        end else if (flush_in) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            valid_out <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (valid_in) begin
                    f3_q  <= funct3_in;
                    acc_q <= {{WIDTH{1'b0}}, mag1};
                    b_q   <= mag2;
                    neg_q <= (funct3_in[2] & funct3_in[1]) ? s1 : s1 ^ s2;
                    if (div_zero || ovf) begin
                        result_q  <= fast_res;
                        valid_out <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        cnt_q   <= CNT_W'(WIDTH);
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        result_q  <= res_d;
                        valid_out <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end
                ST_DONE: if (ready_in) begin
                    valid_out <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ready_out  = state_q == ST_IDLE;
    assign busy_out   = state_q != ST_IDLE;
    assign result_out = result_q;
endmodule

// File: tb/tb_msrv_muldiv_unit.sv
// tb_msrv_muldiv_unit: directed vector table, corner-case sequences and random
// ops checked against a 64-bit arithmetic reference model.
module tb_msrv_muldiv_unit;
    logic        clk = 1'b0, rst = 1'b1;
    logic        valid_in = 1'b0, flush_in = 1'b0, ready_in = 1'b1;
    logic [2:0]  funct3_in = '0;
    logic [31:0] op_1_in = '0, op_2_in = '0;
    logic        ready_out, valid_out, busy_out;
    logic [31:0] result_out;

    logic        v8 = 1'b0, fl8 = 1'b0, ri8 = 1'b1;
    logic [2:0]  f8 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        ro8, vo8, bo8;
    logic [7:0]  r8;

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    msrv_muldiv_unit #(.WIDTH(32)) dut (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
        .valid_in(valid_in), .ready_out(ready_out), .funct3_in(funct3_in),
        .op_1_in(op_1_in), .op_2_in(op_2_in), .flush_in(flush_in),
        .valid_out(valid_out), .ready_in(ready_in), .result_out(result_out),
        .busy_out(busy_out));

    msrv_muldiv_unit #(.WIDTH(8)) dut8 (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
        .valid_in(v8), .ready_out(ro8), .funct3_in(f8),
        .op_1_in(a8), .op_2_in(b8), .flush_in(fl8),
        .valid_out(vo8), .ready_in(ri8), .result_out(r8),
        .busy_out(bo8));

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a, b, exp;
        int          lat;
    } vec_t;
    vec_t vecs[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        logic [63:0] mu = 64'(ua * ub);
        logic [63:0] ms = 64'(sa * sb);
        logic [63:0] msu = 64'(sa * ub);
        case (f)
            3'd0: return mu[31:0];
            3'd1: return ms[63:32];
            3'd2: return msu[63:32];
            3'd3: return mu[63:32];
            3'd4: return b == 0 ? 32'hFFFFFFFF : 32'(sa / sb);
            3'd5: return b == 0 ? 32'hFFFFFFFF : 32'(ua / ub);
            3'd6: return b == 0 ? a : 32'(sa % sb);
            default: return b == 0 ? a : 32'(ua % ub);
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return (f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) ? 1 : 33;
    endfunction

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        for (int i = 0; i < 100 && !ready_out; i++) @(negedge clk);
        chk("issue_ready", ready_out, 1);
        valid_in = 1'b1; funct3_in = f; op_1_in = a; op_2_in = b;
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!valid_out && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        logic [31:0] a, b, held;
        logic [2:0] f;
        logic seen;
        logic [31:0] specials[4];
        specials[0] = 32'h0; specials[1] = 32'h1; specials[2] = 32'hFFFFFFFF; specials[3] = 32'h80000000;

        vecs[0]  = '{3'b000, 32'd5,        32'd3,        32'd15,       33};
        vecs[1]  = '{3'b001, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 33};
        vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33};
        vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
        vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
        vecs[6]  = '{3'b101, 32'd16,       32'd3,        32'd5,        33};
        vecs[7]  = '{3'b111, 32'd16,       32'd3,        32'd1,        33};
        vecs[8]  = '{3'b101, 32'd9,        32'd0,        32'hFFFFFFFF, 1};
        vecs[9]  = '{3'b110, 32'd9,        32'd0,        32'd9,        1};
        vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
        vecs[12] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        33};
        vecs[13] = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33};

        #12 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", ready_out, 1);
        chk("rst_valid", valid_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_result", result_out, 0);

        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].f, vecs[i].a, vecs[i].b);
            wait_valid(lat);
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d_res", i), result_out, vecs[i].exp);
            @(posedge clk); #1;
            if (i == 0) chk("vec0_one_cycle", valid_out, 0);
        end

        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom_range(0, 3) == 0 ? specials[$urandom_range(0, 3)] : $urandom;
            b = $urandom_range(0, 3) == 0 ? specials[$urandom_range(0, 3)] : $urandom;
            issue(f, a, b);
            wait_valid(lat);
            chk($sformatf("rnd%0d_lat f=%0d a=%h b=%h", i, f, a, b), lat, model_lat(f, a, b));
            chk($sformatf("rnd%0d_res f=%0d a=%h b=%h", i, f, a, b), result_out, model(f, a, b));
            @(posedge clk); #1;
        end

        ready_in = 1'b0;
        issue(3'b000, 32'd1234, 32'd5678);
        wait_valid(lat);
        held = result_out;
        chk("bp_res", held, 32'd1234 * 32'd5678);
        @(negedge clk);
        valid_in = 1'b1; funct3_in = 3'b000; op_1_in = 32'd3; op_2_in = 32'd3;
        seen = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen = seen & valid_out & !ready_out & busy_out & (result_out == held);
        end
        chk("bp_stable", seen, 1);
        valid_in = 1'b0; ready_in = 1'b1;
        @(posedge clk); #1;
        chk("bp_drop_valid", valid_out, 0);
        chk("bp_drop_ready", ready_out, 1);
        chk("bp_result_kept", result_out, held);

        issue(3'b000, 32'd11, 32'd13);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush_in = 1'b1;
        @(posedge clk); #1;
        flush_in = 1'b0;
        chk("flush_ready", ready_out, 1);
        chk("flush_busy", busy_out, 0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            seen = seen | valid_out;
        end
        chk("flush_no_valid", seen, 0);

        issue(3'b101, 32'd1000, 32'd7);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("amid_ready", ready_out, 1);
        chk("amid_busy", busy_out, 0);
        chk("amid_valid", valid_out, 0);
        chk("amid_result", result_out, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            seen = seen | valid_out;
        end
        chk("amid_no_valid", seen, 0);

        issue(3'b000, 32'd7, 32'd6);
        wait_valid(lat);
        chk("post_mul_lat", lat, 33);
        chk("post_mul_res", result_out, 42);
        @(posedge clk); #1;

        @(negedge clk);
        v8 = 1'b1; f8 = 3'b101; a8 = 8'd200; b8 = 8'd7;
        @(posedge clk); #1;
        v8 = 1'b0;
        lat = 1;
        while (!vo8 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("w8_divu_lat", lat, 9);
        chk("w8_divu_res", r8, 8'd28);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end
endmodule
